// File: rtl/egg_countdown.sv
`default_nettype none
// ============================================================================
//  Module   : egg_countdown
//  Desc     : MM:SS BCD egg timer. Buttons load minutes/seconds, start_stop
//             runs/pauses, a prescaler counts frame_clk ticks into seconds and
//             an alarm phase of up to ALARM_SECS seconds follows 00:00.
//  Revision : 1.0 - initial release
// ============================================================================
module egg_countdown #(
   parameter int TICKS_PER_SEC = 100,
   parameter int ALARM_SECS    = 10
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       frame_clk,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       set_min,
   input  logic       set_sec,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       alarm,
   output logic       paused
);

   localparam int              c_PW          = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [c_PW-1:0] c_PRESC_LAST  = c_PW'(TICKS_PER_SEC - 1);
   localparam logic [7:0]      c_ALARM_LAST  = 8'(ALARM_SECS - 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_RUN   = 2'd1;
   localparam logic [1:0] c_PAUSE = 2'd2;
   localparam logic [1:0] c_ALARM = 2'd3;

   logic            r_frame_d;
   logic [1:0]      r_state;
   logic [3:0]      r_mt, r_mo, r_st, r_so;
   logic [c_PW-1:0] r_presc;
   logic [7:0]      r_acnt;
   logic            r_running, r_paused, r_alarm;

   logic            w_tick;
   logic [1:0]      w_state_nxt;
   logic [3:0]      w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
   logic [c_PW-1:0] w_presc_nxt;
   logic [7:0]      w_acnt_nxt;
   logic [3:0]      w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
   logic            w_dec_zero, w_time_zero;

   // frame_clk is a data signal; one tick per rising edge of it
   assign w_tick = frame_clk & ~r_frame_d;

   assign w_time_zero = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd0);

   // BCD decrement of the current time by one second, borrowing through digits
   always_comb begin
      w_dec_mt = r_mt;
      w_dec_mo = r_mo;
      w_dec_st = r_st;
      w_dec_so = r_so;
      if (r_so != 4'd0) begin
         w_dec_so = r_so - 4'd1;
      end else begin
         w_dec_so = 4'd9;
         if (r_st != 4'd0) begin
            w_dec_st = r_st - 4'd1;
         end else begin
            w_dec_st = 4'd5;
            if (r_mo != 4'd0) begin
               w_dec_mo = r_mo - 4'd1;
            end else begin
               w_dec_mo = 4'd9;
               w_dec_mt = r_mt - 4'd1;
            end
         end
      end
      w_dec_zero = (w_dec_mt == 4'd0) && (w_dec_mo == 4'd0) &&
                   (w_dec_st == 4'd0) && (w_dec_so == 4'd0);
   end

   // Next-state / next-time logic; clear beats start_stop beats set buttons
   always_comb begin
      w_state_nxt = r_state;
      w_mt_nxt    = r_mt;
      w_mo_nxt    = r_mo;
      w_st_nxt    = r_st;
      w_so_nxt    = r_so;
      w_presc_nxt = r_presc;
      w_acnt_nxt  = r_acnt;
      if (clear) begin
         w_state_nxt = c_IDLE;
         w_mt_nxt    = 4'd0;
         w_mo_nxt    = 4'd0;
         w_st_nxt    = 4'd0;
         w_so_nxt    = 4'd0;
         w_presc_nxt = '0;
         w_acnt_nxt  = 8'd0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start_stop) begin
                  if (!w_time_zero) begin
                     w_state_nxt = c_RUN;
                     w_presc_nxt = '0;
                  end
               end else begin
                  if (set_min) begin
                     if (r_mo == 4'd9) begin
                        w_mo_nxt = 4'd0;
                        w_mt_nxt = (r_mt == 4'd5) ? 4'd0 : r_mt + 4'd1;
                     end else begin
                        w_mo_nxt = r_mo + 4'd1;
                     end
                  end
                  if (set_sec) begin
                     if (r_so == 4'd9) begin
                        w_so_nxt = 4'd0;
                        w_st_nxt = (r_st == 4'd5) ? 4'd0 : r_st + 4'd1;
                     end else begin
                        w_so_nxt = r_so + 4'd1;
                     end
                  end
               end
            end
            c_RUN: begin
               if (start_stop) begin
                  w_state_nxt = c_PAUSE;
               end else if (w_tick) begin
                  if (r_presc == c_PRESC_LAST) begin
                     w_presc_nxt = '0;
                     w_mt_nxt    = w_dec_mt;
                     w_mo_nxt    = w_dec_mo;
                     w_st_nxt    = w_dec_st;
                     w_so_nxt    = w_dec_so;
                     if (w_dec_zero) begin
                        w_state_nxt = c_ALARM;
                        w_acnt_nxt  = 8'd0;
                     end
                  end else begin
                     w_presc_nxt = r_presc + 1'b1;
                  end
               end
            end
            c_PAUSE: begin
               if (start_stop) begin
                  w_state_nxt = c_RUN;
               end
            end
            default: begin
               if (start_stop) begin
                  w_state_nxt = c_IDLE;
                  w_presc_nxt = '0;
                  w_acnt_nxt  = 8'd0;
               end else if (w_tick) begin
                  if (r_presc == c_PRESC_LAST) begin
                     w_presc_nxt = '0;
                     if (r_acnt == c_ALARM_LAST) begin
                        w_state_nxt = c_IDLE;
                        w_acnt_nxt  = 8'd0;
                     end else begin
                        w_acnt_nxt = r_acnt + 8'd1;
                     end
                  end else begin
                     w_presc_nxt = r_presc + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // State, time, counters and registered flags; reset aborts asynchronously
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_frame_d <= 1'b1;
         r_state   <= c_IDLE;
         r_mt      <= 4'd0;
         r_mo      <= 4'd0;
         r_st      <= 4'd0;
         r_so      <= 4'd0;
         r_presc   <= '0;
         r_acnt    <= 8'd0;
         r_running <= 1'b0;
         r_paused  <= 1'b0;
         r_alarm   <= 1'b0;
      end else begin
         r_frame_d <= frame_clk;
         r_state   <= w_state_nxt;
         r_mt      <= w_mt_nxt;
         r_mo      <= w_mo_nxt;
         r_st      <= w_st_nxt;
         r_so      <= w_so_nxt;
         r_presc   <= w_presc_nxt;
         r_acnt    <= w_acnt_nxt;
         r_running <= (w_state_nxt == c_RUN);
         r_paused  <= (w_state_nxt == c_PAUSE);
         r_alarm   <= (w_state_nxt == c_ALARM);
      end
   end

   assign min_tens = r_mt;
   assign min_ones = r_mo;
   assign sec_tens = r_st;
   assign sec_ones = r_so;
   assign running  = r_running;
   assign paused   = r_paused;
   assign alarm    = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_egg_countdown.sv
`default_nettype none
// ============================================================================
//  Module   : tb_egg_countdown
//  Desc     : Scoreboard bench for egg_countdown. The driver pushes the
//             reference model's expected outputs; a monitor pops and compares
//             after every clock edge. Directed scenarios plus random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_egg_countdown;

   localparam int TPS  = 4;
   localparam int ASEC = 3;

   logic       clk_in = 1'b0;
   logic       reset  = 1'b0;
   logic       frame_clk = 1'b1;
   logic       start_stop = 1'b0, clear = 1'b0, set_min = 1'b0, set_sec = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running, alarm, paused;

   egg_countdown #(.TICKS_PER_SEC(TPS), .ALARM_SECS(ASEC)) dut (
      .clk_in(clk_in), .reset(reset), .frame_clk(frame_clk),
      .start_stop(start_stop), .clear(clear), .set_min(set_min), .set_sec(set_sec),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .running(running), .alarm(alarm), .paused(paused)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_fail   = 0;
   logic [18:0] q_exp[$];

   // Reference model: time kept as plain minutes/seconds integers
   int m_mm, m_ss, m_p, m_a, m_st, m_fprev;  // m_st: 0 idle, 1 run, 2 pause, 3 alarm

   function automatic logic [18:0] pack(int mm, int ss, int st);
      logic [3:0] a, b, c, d;
      a = 4'(mm / 10); b = 4'(mm % 10); c = 4'(ss / 10); d = 4'(ss % 10);
      return {a, b, c, d, st == 1, st == 2, st == 3};
   endfunction

   function automatic logic [18:0] dut_vec();
      return {min_tens, min_ones, sec_tens, sec_ones, running, paused, alarm};
   endfunction

   task automatic model_reset();
      m_mm = 0; m_ss = 0; m_p = 0; m_a = 0; m_st = 0; m_fprev = 1;
   endtask

   task automatic model_step(input bit ss, input bit clr, input bit smin, input bit ssec, input bit fr);
      bit tk;
      int total;
      tk = fr && !m_fprev;
      m_fprev = fr;
      if (clr) begin
         m_st = 0; m_mm = 0; m_ss = 0; m_p = 0; m_a = 0;
      end else begin
         case (m_st)
            0: if (ss) begin
                  if (m_mm * 60 + m_ss != 0) begin m_st = 1; m_p = 0; end
               end else begin
                  if (smin) m_mm = (m_mm + 1) % 60;
                  if (ssec) m_ss = (m_ss + 1) % 60;
               end
            1: if (ss) m_st = 2;
               else if (tk) begin
                  if (m_p == TPS - 1) begin
                     m_p = 0;
                     total = m_mm * 60 + m_ss - 1;
                     m_mm = total / 60; m_ss = total % 60;
                     if (total == 0) begin m_st = 3; m_a = 0; end
                  end else m_p++;
               end
            2: if (ss) m_st = 1;
            default: if (ss) begin m_st = 0; m_p = 0; m_a = 0; end
               else if (tk) begin
                  if (m_p == TPS - 1) begin
                     m_p = 0; m_a++;
                     if (m_a == ASEC) begin m_st = 0; m_a = 0; end
                  end else m_p++;
               end
         endcase
      end
   endtask

   // One clock cycle: drive at the falling edge, queue the expectation, advance
   task automatic step(input bit ss, input bit clr, input bit smin, input bit ssec, input bit fr);
      start_stop = ss; clear = clr; set_min = smin; set_sec = ssec; frame_clk = fr;
      model_step(ss, clr, smin, ssec, fr);
      q_exp.push_back(pack(m_mm, m_ss, m_st));
      @(negedge clk_in);
   endtask

   task automatic idle_step(); step(0, 0, 0, 0, frame_clk); endtask
   task automatic press_ss();  step(1, 0, 0, 0, frame_clk); endtask
   task automatic press_clr(); step(0, 1, 0, 0, frame_clk); endtask
   task automatic tick();      step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 1); endtask
   task automatic ticks(input int n); for (int i = 0; i < n; i++) tick(); endtask
   task automatic load(input int mins, input int secs);
      for (int i = 0; i < mins; i++) step(0, 0, 1, 0, frame_clk);
      for (int i = 0; i < secs; i++) step(0, 0, 0, 1, frame_clk);
   endtask

   // Direct comparison against constant expectations for named scenarios
   task automatic spot(input string name, input int mm, input int ss, input int st);
      logic [18:0] e;
      e = pack(mm, ss, st);
      n_checks++;
      if (dut_vec() !== e) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, dut_vec(), e);
      end
   endtask

   task automatic do_reset(input bit fr);
      frame_clk = fr;
      #2 reset = 1'b0;
      #1 spot("async_reset", 0, 0, 0);
      model_reset();
      @(negedge clk_in);
      @(negedge clk_in);
      reset = 1'b1;
   endtask

   // Monitor: every edge presents an output; compare against the queue head
   initial begin
      logic [18:0] e;
      forever begin
         @(posedge clk_in);
         #1;
         if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_checks++;
            if (dut_vec() !== e) begin
               n_fail++;
               $display("FAIL scoreboard @%0t: got %h required %h", $time, dut_vec(), e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      @(negedge clk_in);
      @(negedge clk_in);
      spot("reset_state", 0, 0, 0);
      // frame_clk high across reset release must not produce a tick
      reset = 1'b1;
      load(0, 1); press_ss();
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
      spot("no_tick_after_reset", 0, 1, 1);
      press_clr();

      load(2, 5); press_ss();
      spot("start_0205", 2, 5, 1);
      ticks(4); spot("after_4_ticks", 2, 4, 1);
      ticks(4); spot("after_8_ticks", 2, 3, 1);
      press_clr();

      load(1, 0); press_ss(); ticks(4); spot("borrow_0059", 0, 59, 1);
      press_clr();
      load(10, 0); press_ss(); ticks(4); spot("borrow_0959", 9, 59, 1);
      press_clr();
      load(0, 1); press_ss(); ticks(4); spot("reach_alarm", 0, 0, 3);
      press_clr();

      load(0, 10); press_ss(); ticks(2); press_ss();
      ticks(10); spot("paused_hold", 0, 10, 2);
      press_ss(); ticks(2); spot("resume_dec", 0, 9, 1);
      press_clr();

      load(0, 60); spot("sec_wrap", 0, 0, 0);
      load(60, 0); spot("min_wrap", 0, 0, 0);
      press_ss(); spot("start_at_zero", 0, 0, 0);

      load(0, 1); press_ss(); ticks(4);
      ticks(11); spot("alarm_before_end", 0, 0, 3);
      ticks(1); spot("alarm_timeout", 0, 0, 0);
      load(0, 1); press_ss(); ticks(4); ticks(2);
      press_clr(); spot("alarm_clear", 0, 0, 0);

      load(1, 0); press_ss(); ticks(1);
      step(1, 1, 0, 0, frame_clk); spot("clear_beats_ss", 0, 0, 0);

      load(3, 2); press_ss(); ticks(3);
      do_reset(1'b0);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset(1'($urandom_range(0, 1)));
         end else begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 1'($urandom_range(0, 1)));
         end
      end

      @(negedge clk_in);
      n_checks++;
      if (q_exp.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d left required 0", q_exp.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
